// File: rtl/alu_nic_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_nic_rr
//  Purpose  : Round-robin lease interconnect between CLIENTS_N requesters and
//             ALUS_N alu_core instances. A client that holds client_cycle high
//             is leased one ALU. While the lease lasts, the client's
//             cycle/strobe/req are routed to that ALU and the ALU's
//             ack/stall/rsp are routed back, with no added latency.
//  Ports    : clk, reset (async, active high)
//             client_cycle/strobe/req  -> in,  per client
//             client_ack/stall/rsp     <- out, per client
//             alu_cycle/strobe/req     <- out, per ALU
//             alu_ack/stall/rsp        -> in,  per ALU
//             alu_busy                 <- out, lease state per ALU
//  Revision : 1.0  initial release
// ============================================================================
module alu_nic_rr #(
    parameter int CLIENTS_N = 4,
    parameter int ALUS_N    = 2,
    parameter int REQ_W     = 177,
    parameter int RSP_W     = 96,
    parameter int CIDX_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CLIENTS_N-1:0]       client_cycle,
    input  logic [CLIENTS_N-1:0]       client_strobe,
    input  logic [REQ_W*CLIENTS_N-1:0] client_req,
    output logic [CLIENTS_N-1:0]       client_ack,
    output logic [CLIENTS_N-1:0]       client_stall,
    output logic [RSP_W*CLIENTS_N-1:0] client_rsp,
    output logic [ALUS_N-1:0]          alu_cycle,
    output logic [ALUS_N-1:0]          alu_strobe,
    output logic [REQ_W*ALUS_N-1:0]    alu_req,
    input  logic [ALUS_N-1:0]          alu_ack,
    input  logic [ALUS_N-1:0]          alu_stall,
    input  logic [RSP_W*ALUS_N-1:0]    alu_rsp,
    output logic [ALUS_N-1:0]          alu_busy
);

    localparam int c_aidx_w = (ALUS_N > 1) ? $clog2(ALUS_N) : 1;

    typedef enum logic [0:0] {
        ST_FREE  = 1'b0,
        ST_OWNED = 1'b1
    } alu_state_t;

    alu_state_t        r_state     [ALUS_N];
    logic [CIDX_W-1:0] r_owner     [ALUS_N];
    logic [CIDX_W-1:0] r_rr_ptr;

    alu_state_t        w_state_nxt [ALUS_N];
    logic [CIDX_W-1:0] w_owner_nxt [ALUS_N];
    logic [CIDX_W-1:0] w_rr_nxt;

    logic [CLIENTS_N-1:0] w_has_alu;
    logic                 w_cand_found;
    logic [CIDX_W-1:0]    w_cand;
    logic                 w_free_found;
    logic [c_aidx_w-1:0]  w_free;

    // Client index reached by stepping 'off' places from 'base' with wrap.
    function automatic int f_wrap(input int base, input int off);
        int s;
        s = base + off;
        if (s >= CLIENTS_N) s = s - CLIENTS_N;
        return s;
    endfunction

    // Which clients currently hold a lease; such clients are never candidates.
    always_comb begin
        w_has_alu = '0;
        for (int j = 0; j < ALUS_N; j++) begin
            if (r_state[j] == ST_OWNED) w_has_alu[r_owner[j]] = 1'b1;
        end
    end

    // First requesting, unleased client at or after the round-robin pointer.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand       = '0;
        for (int k = 0; k < CLIENTS_N; k++) begin
            if (!w_cand_found &&
                client_cycle[f_wrap(int'(r_rr_ptr), k)] &&
                !w_has_alu[f_wrap(int'(r_rr_ptr), k)]) begin
                w_cand_found = 1'b1;
                w_cand       = CIDX_W'(f_wrap(int'(r_rr_ptr), k));
            end
        end
    end

    // Lowest-index ALU that is FREE in the current state. An ALU being
    // released this cycle is still OWNED here, so it cannot be regranted
    // until the following cycle.
    always_comb begin
        w_free_found = 1'b0;
        w_free       = '0;
        for (int j = 0; j < ALUS_N; j++) begin
            if (!w_free_found && r_state[j] == ST_FREE) begin
                w_free_found = 1'b1;
                w_free       = c_aidx_w'(j);
            end
        end
    end

    // Next-state: releases first, then at most one new grant.
    always_comb begin
        w_rr_nxt = r_rr_ptr;
        for (int j = 0; j < ALUS_N; j++) begin
            w_state_nxt[j] = r_state[j];
            w_owner_nxt[j] = r_owner[j];
            if (r_state[j] == ST_OWNED && !client_cycle[r_owner[j]]) begin
                w_state_nxt[j] = ST_FREE;
            end
        end
        if (w_cand_found && w_free_found) begin
            w_state_nxt[w_free] = ST_OWNED;
            w_owner_nxt[w_free] = w_cand;
            w_rr_nxt = (int'(w_cand) == CLIENTS_N - 1) ? '0 : w_cand + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < ALUS_N; j++) begin
                r_state[j] <= ST_FREE;
                r_owner[j] <= '0;
            end
            r_rr_ptr <= '0;
        end else begin
            for (int j = 0; j < ALUS_N; j++) begin
                r_state[j] <= w_state_nxt[j];
                r_owner[j] <= w_owner_nxt[j];
            end
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Routing is purely combinational from the lease state, so a reset
    // clears every path in the same cycle it is asserted. alu_busy is a
    // direct decode of the state flops.
    always_comb begin
        alu_cycle    = '0;
        alu_strobe   = '0;
        alu_req      = '0;
        alu_busy     = '0;
        client_ack   = '0;
        client_stall = '1;
        client_rsp   = '0;
        for (int j = 0; j < ALUS_N; j++) begin
            if (r_state[j] == ST_OWNED) begin
                alu_busy[j]   = 1'b1;
                alu_cycle[j]  = client_cycle[r_owner[j]];
                alu_strobe[j] = client_strobe[r_owner[j]];
                alu_req[REQ_W*j +: REQ_W] =
                    client_req[REQ_W*int'(r_owner[j]) +: REQ_W];
                client_ack[r_owner[j]]   = alu_ack[j];
                client_stall[r_owner[j]] = alu_stall[j];
                client_rsp[RSP_W*int'(r_owner[j]) +: RSP_W] =
                    alu_rsp[RSP_W*j +: RSP_W];
            end
        end
    end

endmodule
`default_nettype wire
